sm_dbg_ctrl: RTL and testbench

SM_DBG_CTRL -- requirements
Module: sm_dbg_ctrl

---
 rtl/sm_dbg_ctrl_pkg.sv | 27 ++
 rtl/sm_dbg_ctrl_if.sv | 26 ++
 rtl/sm_debounce.sv | 60 ++++++
 rtl/sm_dbg_ctrl.sv | 121 ++++++++++++
 tb/tb_sm_dbg_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sm_dbg_ctrl_pkg.sv
// Shared definitions for the single-step debug controller: FSM state
// encodings (also used by the board-level tops), bus widths and the
// register-address stepping helper.
package sm_dbg_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef logic [1:0] dbgState_t;

    localparam dbgState_t ST_RUN  = 2'd0;
    localparam dbgState_t ST_HALT = 2'd1;
    localparam dbgState_t ST_STEP = 2'd2;

    // Next viewed register address, wrapping back to zero past the last one.
    function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] maxAddr);
        logic [ADDR_W-1:0] result;
        if (addr >= maxAddr) begin
            result = '0;
        end else begin
            result = addr + 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sm_dbg_ctrl_if.sv
// Debug bus between the controller, the CPU clock divider and the register
// file read port. The controller is the master: it gates the CPU clock and
// selects which register is read back for display.
interface sm_dbg_ctrl_if;
    import sm_dbg_ctrl_pkg::*;

    logic              clkEnable;
    logic              cpuTick;
    logic [ADDR_W-1:0] regAddr;
    logic [DATA_W-1:0] regData;

    modport master (
        output clkEnable,
        output regAddr,
        input  cpuTick,
        input  regData
    );

    modport slave (
        input  clkEnable,
        input  regAddr,
        output cpuTick,
        output regData
    );

endinterface

// File: rtl/sm_debounce.sv
// Push-button conditioner: two-flop synchronizer, saturating debounce
// counter and a one-cycle press pulse on an accepted high-to-low change.
module sm_debounce #(
    parameter int DEBOUNCE_W = 16
) (
    input  logic clkIn,
    input  logic rst_n,
    input  logic key_i,
    output logic press_o
);

    logic [1:0]            sync_q;
    logic [DEBOUNCE_W-1:0] count_q;
    logic [DEBOUNCE_W-1:0] count_d;
    logic                  level_q;
    logic                  level_d;
    logic                  press_q;
    logic                  press_d;

    // Bring the raw key into the clock domain; idle (released) level is 1.
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_i};
        end
    end

    // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts the count.
    always_comb begin
        count_d = count_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] == level_q) begin
            count_d = '0;
        end else if (count_q == '1) begin
            level_d = sync_q[1];
            count_d = '0;
            press_d = ~sync_q[1];
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Debounce state and the registered press pulse.
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            count_q <= count_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/sm_dbg_ctrl.sv
// Single-step debug controller: RUN/HALT/STEP clock gating driven by three
// debounced push-buttons, plus the register-view address counter and the
// registered display value.
module sm_dbg_ctrl
    import sm_dbg_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_W = 16,
    parameter int RESET_RUN  = 1,
    parameter int REG_MAX    = 31
) (
    input  logic              clkIn,
    input  logic              rst_n,
    input  logic              keyMode,
    input  logic              keyStep,
    input  logic              keyReg,
    sm_dbg_ctrl_if.master     dbg,
    output logic [DATA_W-1:0] dispData,
    output logic              running
);

    localparam dbgState_t         ResetStateC = (RESET_RUN != 0) ? ST_RUN : ST_HALT;
    localparam logic              ResetEnC    = (RESET_RUN != 0);
    localparam logic [ADDR_W-1:0] RegMaxC     = ADDR_W'(REG_MAX);

    logic              modePress;
    logic              stepPress;
    logic              regPress;
    dbgState_t         state_q;
    dbgState_t         state_d;
    logic              clkEnable_q;
    logic              running_q;
    logic [ADDR_W-1:0] regAddr_q;
    logic [ADDR_W-1:0] regAddr_d;
    logic [DATA_W-1:0] dispData_q;

    sm_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) uModeKey (
        .clkIn   (clkIn),
        .rst_n   (rst_n),
        .key_i   (keyMode),
        .press_o (modePress)
    );

    sm_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) uStepKey (
        .clkIn   (clkIn),
        .rst_n   (rst_n),
        .key_i   (keyStep),
        .press_o (stepPress)
    );

    sm_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) uRegKey (
        .clkIn   (clkIn),
        .rst_n   (rst_n),
        .key_i   (keyReg),
        .press_o (regPress)
    );

    // Mode/step transitions; mode has priority in HALT and STEP ignores keys until its single tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (modePress) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (modePress) begin
                    state_d = ST_RUN;
                end else if (stepPress) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (dbg.cpuTick) begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ResetStateC;
            end
        endcase
    end

    // State plus registered decode of the next state, so the gate closes right after the admitted tick.
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ResetStateC;
            clkEnable_q <= ResetEnC;
            running_q   <= ResetEnC;
        end else begin
            state_q     <= state_d;
            clkEnable_q <= (state_d != ST_HALT);
            running_q   <= (state_d == ST_RUN);
        end
    end

    // Viewed register advances on each reg press regardless of the CPU clock state.
    always_comb begin
        regAddr_d = regAddr_q;
        if (regPress) begin
            regAddr_d = nextAddr(regAddr_q, RegMaxC);
        end
    end

    // Address register and one-cycle-delayed capture of the register file read data.
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            regAddr_q  <= '0;
            dispData_q <= '0;
        end else begin
            regAddr_q  <= regAddr_d;
            dispData_q <= dbg.regData;
        end
    end

    assign dbg.clkEnable = clkEnable_q;
    assign dbg.regAddr   = regAddr_q;
    assign dispData      = dispData_q;
    assign running       = running_q;

endmodule

// File: tb/tb_sm_dbg_ctrl.sv
// Directed bench for sm_dbg_ctrl with a short debounce window (16 samples)
// and HALT as the reset state. A toy register file answers reads with
// 32'hDEADBEEF xor the address so display values track the address.
module tb_sm_dbg_ctrl;
    import sm_dbg_ctrl_pkg::*;

    logic        clkIn   = 1'b0;
    logic        rst_n   = 1'b0;
    logic        keyMode = 1'b1;
    logic        keyStep = 1'b1;
    logic        keyReg  = 1'b1;
    logic        tick    = 1'b0;
    logic [31:0] dispData;
    logic        running;

    int total = 0;
    int bad   = 0;

    sm_dbg_ctrl_if dbg();

    assign dbg.cpuTick = tick;
    assign dbg.regData = 32'hDEADBEEF ^ {27'd0, dbg.regAddr};

    sm_dbg_ctrl #(
        .DEBOUNCE_W (4),
        .RESET_RUN  (0),
        .REG_MAX    (31)
    ) dut (
        .clkIn    (clkIn),
        .rst_n    (rst_n),
        .keyMode  (keyMode),
        .keyStep  (keyStep),
        .keyReg   (keyReg),
        .dbg      (dbg),
        .dispData (dispData),
        .running  (running)
    );

    always #5 clkIn = ~clkIn;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    // which: 0 = mode, 1 = step, 2 = reg, 3 = mode and step together
    task automatic applyStimulus(input int which, input int lowCycles, input int highCycles);
        if (which == 0 || which == 3) keyMode = 1'b0;
        if (which == 1 || which == 3) keyStep = 1'b0;
        if (which == 2) keyReg = 1'b0;
        cycles(lowCycles);
        keyMode = 1'b1;
        keyStep = 1'b1;
        keyReg  = 1'b1;
        cycles(highCycles);
    endtask

    task automatic waitEnable(input logic val, input int limit, output int lat);
        lat = 0;
        while (dbg.clkEnable !== val && lat < limit) begin
            @(negedge clkIn);
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          lat;
        int          admitted;
        int          n;
        logic        sawStep;
        logic        sawEn;
        logic [4:0]  expAddr;

        // reset state
        cycles(3);
        checkOutput("rst_clkEnable", {31'd0, dbg.clkEnable}, 32'd0);
        checkOutput("rst_running", {31'd0, running}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_clkEnable", {31'd0, dbg.clkEnable}, 32'd0);
        checkOutput("rel_running", {31'd0, running}, 32'd0);
        checkOutput("rel_regAddr", {27'd0, dbg.regAddr}, 32'd0);
        checkOutput("rel_dispData", dispData, 32'd0);
        cycles(3);

        // single step: one tick admitted, then gate closes
        keyStep = 1'b0;
        waitEnable(1'b1, 40, lat);
        checkOutput("step_latency_in_18_21", {31'd0, (lat >= 18 && lat <= 21)}, 32'd1);
        checkOutput("step_running", {31'd0, running}, 32'd0);
        cycles(2);
        checkOutput("step_held_open", {31'd0, dbg.clkEnable}, 32'd1);
        admitted = 0;
        for (int k = 0; k < 3; k++) begin
            if (dbg.clkEnable === 1'b1) admitted++;
            tick = 1'b1;
            cycles(1);
            tick = 1'b0;
            if (k == 0) checkOutput("step_closed_after_tick", {31'd0, dbg.clkEnable}, 32'd0);
            cycles(3);
        end
        checkOutput("step_ticks_admitted", admitted, 32'd1);
        cycles(7);
        keyStep = 1'b1;
        cycles(30);
        checkOutput("step_release_clkEnable", {31'd0, dbg.clkEnable}, 32'd0);
        checkOutput("step_release_running", {31'd0, running}, 32'd0);

        // mode toggles, step ignored in RUN, short glitch ignored
        applyStimulus(0, 40, 30);
        checkOutput("mode1_running", {31'd0, running}, 32'd1);
        checkOutput("mode1_clkEnable", {31'd0, dbg.clkEnable}, 32'd1);
        applyStimulus(1, 40, 30);
        checkOutput("run_step_ignored_running", {31'd0, running}, 32'd1);
        checkOutput("run_step_ignored_clkEnable", {31'd0, dbg.clkEnable}, 32'd1);
        applyStimulus(0, 40, 30);
        checkOutput("mode2_running", {31'd0, running}, 32'd0);
        checkOutput("mode2_clkEnable", {31'd0, dbg.clkEnable}, 32'd0);
        applyStimulus(0, 10, 30);
        checkOutput("glitch_running", {31'd0, running}, 32'd0);
        checkOutput("glitch_clkEnable", {31'd0, dbg.clkEnable}, 32'd0);

        // register view: first press with display latency, then wrap through 31 to 0
        expAddr = 5'd0;
        keyReg = 1'b0;
        n = 0;
        while (dbg.regAddr === expAddr && n < 40) begin
            @(negedge clkIn);
            n++;
        end
        checkOutput("reg_first_addr", {27'd0, dbg.regAddr}, 32'd1);
        checkOutput("reg_disp_old", dispData, 32'hDEADBEEF);
        cycles(1);
        checkOutput("reg_disp_new", dispData, 32'hDEADBEEE);
        cycles(20);
        keyReg = 1'b1;
        cycles(25);
        for (int i = 2; i <= 32; i++) begin
            if (i == 5) tick = 1'b1;
            applyStimulus(2, 25, 25);
            tick = 1'b0;
            expAddr = 5'(i % 32);
            checkOutput($sformatf("reg_addr_%0d", i), {27'd0, dbg.regAddr}, {27'd0, expAddr});
            checkOutput($sformatf("reg_disp_%0d", i), dispData, 32'hDEADBEEF ^ {27'd0, expAddr});
        end

        // mode and step pressed together in HALT: mode wins
        keyMode = 1'b0;
        keyStep = 1'b0;
        sawStep = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (c == 40) begin
                keyMode = 1'b1;
                keyStep = 1'b1;
            end
            @(negedge clkIn);
            if (dbg.clkEnable === 1'b1 && running === 1'b0) sawStep = 1'b1;
        end
        checkOutput("both_no_step", {31'd0, sawStep}, 32'd0);
        checkOutput("both_running", {31'd0, running}, 32'd1);
        checkOutput("both_clkEnable", {31'd0, dbg.clkEnable}, 32'd1);
        applyStimulus(0, 40, 30);
        checkOutput("back_to_halt", {31'd0, running}, 32'd0);

        // reset in the middle of a step
        keyStep = 1'b0;
        waitEnable(1'b1, 40, lat);
        checkOutput("midstep_entered", {31'd0, dbg.clkEnable}, 32'd1);
        keyStep = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midstep_rst_clkEnable", {31'd0, dbg.clkEnable}, 32'd0);
        checkOutput("midstep_rst_running", {31'd0, running}, 32'd0);
        checkOutput("midstep_rst_regAddr", {27'd0, dbg.regAddr}, 32'd0);
        checkOutput("midstep_rst_dispData", dispData, 32'd0);
        cycles(3);
        rst_n = 1'b1;
        sawEn = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clkIn);
            if (dbg.clkEnable !== 1'b0) sawEn = 1'b1;
        end
        checkOutput("midstep_no_late_step", {31'd0, sawEn}, 32'd0);
        checkOutput("midstep_halt_running", {31'd0, running}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
